// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg
// Shared definitions for the truth-table sweep checker.
//   sweep_state_t : controller state encoding (IDLE, SETTLE, CHECK, DONE)
//   FK_DISAGREE   : fail_kind bit set when the implementations disagree
//   FK_WRONG      : fail_kind bit set when impl_out[0] differs from the table
package tt_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } sweep_state_t;

   localparam int FK_DISAGREE = 0;
   localparam int FK_WRONG    = 1;

endpackage

// File: rtl/tt_sweep_cmp.sv
// tt_sweep_cmp
// Combinational comparator for one stimulus vector.
// Ports:
//   impl_out     [NUM_IMPL] : output bit of each implementation under test
//   expected_bit            : reference value f(stim) from the latched table
//   disagree                : implementations do not all produce the same bit
//   wrong                   : impl_out[0] differs from the reference value
module tt_sweep_cmp #(
   parameter int NUM_IMPL = 3
) (
   input  logic [NUM_IMPL-1:0] impl_out,
   input  logic                expected_bit,
   output logic                disagree,
   output logic                wrong
);

   // All bits agree only when they are all ones or all zeros, so any mix of
   // ones and zeros means at least one implementation differs.
   assign disagree = (|impl_out) & ~(&impl_out);

   // Implementation 0 stands in for the group when checking against the table;
   // any other implementation that differs is already caught by disagree.
   assign wrong = impl_out[0] ^ expected_bit;

endmodule

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl
// Clocked self-test sequencer. Walks every IN_W-bit vector, holds each one for
// SETTLE_CYC cycles, then checks the implementations against each other and
// against the expected truth table latched at start.
// Ports:
//   clk, rst             : clock (rising edge), async active-high reset
//   start                : begin a sweep (accepted only in IDLE or DONE)
//   expected [2**IN_W]   : truth table, bit i = f(i), latched on start
//   impl_out [NUM_IMPL]  : output bit of each implementation
//   stim     [IN_W]      : vector driven to all implementations
//   busy                 : sweep in progress
//   done                 : sweep finished, held until next start or reset
//   pass                 : no failure seen (valid while done)
//   fail_idx [IN_W]      : first failing vector
//   fail_kind[2]         : {wrong, disagree} captured at first failure
//   err_cnt  [IN_W+1]    : number of failing vectors
// Configuration macro:
//   TT_SWEEP_ERR_CNT_EN  : when defined the sweep always covers every vector
//                          and err_cnt counts failures; when undefined the
//                          sweep stops at the first failure and err_cnt is 0.
module tt_sweep_ctrl
   import tt_sweep_pkg::*;
#(
   parameter int IN_W       = 4,
   parameter int NUM_IMPL   = 3,
   parameter int SETTLE_CYC = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2**IN_W-1:0]    expected,
   input  logic [NUM_IMPL-1:0]   impl_out,
   output logic [IN_W-1:0]       stim,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [IN_W-1:0]       fail_idx,
   output logic [1:0]            fail_kind,
   output logic [IN_W:0]         err_cnt
);

   localparam int               CNT_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [IN_W-1:0]  STIM_LAST   = '1;

   sweep_state_t        state_q;
   logic [CNT_W-1:0]    settle_cnt;
   logic [2**IN_W-1:0]  expected_q;
   logic                disagree;
   logic                wrong;
   logic                fail_now;
   logic                stop_now;
   logic                start_ok;

   tt_sweep_cmp #(
      .NUM_IMPL(NUM_IMPL)
   ) u_cmp (
      .impl_out    (impl_out),
      .expected_bit(expected_q[stim]),
      .disagree    (disagree),
      .wrong       (wrong)
   );

   assign fail_now = disagree | wrong;

   // start is only looked at through the registered state, so a start that
   // coincides with the edge entering DONE is not seen until DONE is visible.
   assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

   // The last vector always ends the sweep; without the counting feature the
   // first failure ends it too, since nothing more would be reported.
`ifdef TT_SWEEP_ERR_CNT_EN
   assign stop_now = (stim == STIM_LAST);
`else
   assign stop_now = (stim == STIM_LAST) || fail_now;
`endif

   // Main sequencer. pass doubles as the "no failure yet" flag, which is what
   // limits fail_idx/fail_kind capture to the first failing vector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         settle_cnt <= '0;
         expected_q <= '0;
         stim       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail_idx   <= '0;
         fail_kind  <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start_ok) begin
                  expected_q <= expected;
                  stim       <= '0;
                  settle_cnt <= '0;
                  pass       <= 1'b1;
                  fail_idx   <= '0;
                  fail_kind  <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  state_q    <= SETTLE;
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state_q <= CHECK;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            CHECK: begin
               if (fail_now) begin
                  pass <= 1'b0;
                  if (pass) begin
                     fail_idx               <= stim;
                     fail_kind[FK_WRONG]    <= wrong;
                     fail_kind[FK_DISAGREE] <= disagree;
                  end
               end
               if (stop_now) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= DONE;
               end else begin
                  stim       <= stim + 1'b1;
                  settle_cnt <= '0;
                  state_q    <= SETTLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef TT_SWEEP_ERR_CNT_EN
   localparam logic [IN_W:0] ERR_MAX = (IN_W+1)'(2**IN_W);

   // Failing-vector counter, cleared on an accepted start and saturating at
   // the number of vectors in a sweep.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (start_ok) begin
         err_cnt <= '0;
      end else if ((state_q == CHECK) && fail_now && (err_cnt != ERR_MAX)) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb_tt_sweep_ctrl
// Directed bench for tt_sweep_ctrl. One instance uses the default parameters,
// a second uses SETTLE_CYC=3. The implementations under test are modelled as
// three copies of f = 1 for {5,7,14,15}, with selectable injected faults.
// Expectations follow TT_SWEEP_ERR_CNT_EN when it is defined for the build.
module tb_tt_sweep_ctrl;

`ifdef TT_SWEEP_ERR_CNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] expected;
   logic [2:0]  impl_out;
   logic [3:0]  stim;
   logic        busy;
   logic        done;
   logic        pass;
   logic [3:0]  fail_idx;
   logic [1:0]  fail_kind;
   logic [4:0]  err_cnt;

   logic        start3;
   logic [15:0] expected3;
   logic [2:0]  impl_out3;
   logic [3:0]  stim3;
   logic        busy3;
   logic        done3;
   logic        pass3;
   logic [3:0]  fail_idx3;
   logic [1:0]  fail_kind3;
   logic [4:0]  err_cnt3;

   logic [15:0] tt_ref = 16'hC0A0;
   int          fault_mode;
   int          checks;
   int          errors;

   tt_sweep_ctrl #(.IN_W(4), .NUM_IMPL(3), .SETTLE_CYC(1)) dut (
      .clk(clk), .rst(rst), .start(start), .expected(expected),
      .impl_out(impl_out), .stim(stim), .busy(busy), .done(done),
      .pass(pass), .fail_idx(fail_idx), .fail_kind(fail_kind), .err_cnt(err_cnt)
   );

   tt_sweep_ctrl #(.IN_W(4), .NUM_IMPL(3), .SETTLE_CYC(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .expected(expected3),
      .impl_out(impl_out3), .stim(stim3), .busy(busy3), .done(done3),
      .pass(pass3), .fail_idx(fail_idx3), .fail_kind(fail_kind3), .err_cnt(err_cnt3)
   );

   // Free-running 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Implementation models: all three compute the reference function; the
   // fault modes force impl 1 high at vector 3, or all outputs low at 14.
   always_comb begin
      impl_out = {3{tt_ref[stim]}};
      if (fault_mode == 1 && stim == 4'd3) impl_out[1] = 1'b1;
      if (fault_mode == 2 && stim == 4'd14) impl_out = 3'b000;
   end

   always_comb begin
      impl_out3 = {3{tt_ref[stim3]}};
   end

   // Pulse start for one edge on the default instance; returns #1 after that
   // edge with the sweep's first SETTLE state visible.
   task automatic start_sweep(input logic [15:0] table_val);
      @(negedge clk);
      expected = table_val;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Count edges until done is seen, bounded at 200 cycles.
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   // Reset values while rst is held, and after release with start idle.
   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks += 7;
      if (stim !== 4'd0)      begin errors++; $display("[TB] FAIL reset_stim: got %0d, expected 0", stim); end
      if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL reset_busy: got %0b, expected 0", busy); end
      if (done !== 1'b0)      begin errors++; $display("[TB] FAIL reset_done: got %0b, expected 0", done); end
      if (pass !== 1'b0)      begin errors++; $display("[TB] FAIL reset_pass: got %0b, expected 0", pass); end
      if (fail_idx !== 4'd0)  begin errors++; $display("[TB] FAIL reset_fail_idx: got %0d, expected 0", fail_idx); end
      if (fail_kind !== 2'd0) begin errors++; $display("[TB] FAIL reset_fail_kind: got %0d, expected 0", fail_kind); end
      if (err_cnt !== 5'd0)   begin errors++; $display("[TB] FAIL reset_err_cnt: got %0d, expected 0", err_cnt); end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks += 2;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %0b, expected 0", busy); end
      if (done !== 1'b0) begin errors++; $display("[TB] FAIL idle_done: got %0b, expected 0", done); end
   endtask

   // Clean sweep with correct implementations: 32 cycles to done, pass=1.
   task automatic test_pass_sweep;
      int cyc;
      fault_mode = 0;
      start_sweep(16'hC0A0);
      checks += 2;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL pass_busy_start: got %0b, expected 1", busy); end
      if (stim !== 4'd0) begin errors++; $display("[TB] FAIL pass_stim_start: got %0d, expected 0", stim); end
      wait_done(cyc);
      checks += 7;
      if (cyc != 32)          begin errors++; $display("[TB] FAIL pass_cycles: got %0d, expected 32", cyc); end
      if (pass !== 1'b1)      begin errors++; $display("[TB] FAIL pass_pass: got %0b, expected 1", pass); end
      if (fail_idx !== 4'd0)  begin errors++; $display("[TB] FAIL pass_fail_idx: got %0d, expected 0", fail_idx); end
      if (fail_kind !== 2'd0) begin errors++; $display("[TB] FAIL pass_fail_kind: got %0d, expected 0", fail_kind); end
      if (err_cnt !== 5'd0)   begin errors++; $display("[TB] FAIL pass_err_cnt: got %0d, expected 0", err_cnt); end
      if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL pass_busy_end: got %0b, expected 0", busy); end
      if (stim !== 4'd15)     begin errors++; $display("[TB] FAIL pass_stim_end: got %0d, expected 15", stim); end
      repeat (3) @(posedge clk);
      #1;
      checks += 2;
      if (done !== 1'b1) begin errors++; $display("[TB] FAIL pass_done_held: got %0b, expected 1", done); end
      if (pass !== 1'b1) begin errors++; $display("[TB] FAIL pass_pass_held: got %0b, expected 1", pass); end
   endtask

   // impl 1 disagrees at vector 3 only.
   task automatic test_disagree;
      int cyc;
      int exp_cyc;
      logic [4:0] exp_err;
      exp_cyc = ERR_EN ? 32 : 8;
      exp_err = ERR_EN ? 5'd1 : 5'd0;
      fault_mode = 1;
      start_sweep(16'hC0A0);
      wait_done(cyc);
      checks += 5;
      if (cyc != exp_cyc)         begin errors++; $display("[TB] FAIL dis_cycles: got %0d, expected %0d", cyc, exp_cyc); end
      if (pass !== 1'b0)          begin errors++; $display("[TB] FAIL dis_pass: got %0b, expected 0", pass); end
      if (fail_idx !== 4'd3)      begin errors++; $display("[TB] FAIL dis_fail_idx: got %0d, expected 3", fail_idx); end
      if (fail_kind !== 2'b01)    begin errors++; $display("[TB] FAIL dis_fail_kind: got %0d, expected 1", fail_kind); end
      if (err_cnt !== exp_err)    begin errors++; $display("[TB] FAIL dis_err_cnt: got %0d, expected %0d", err_cnt, exp_err); end
      fault_mode = 0;
   endtask

   // All implementations return 0 at vector 14 where the table says 1.
   task automatic test_wrong;
      int cyc;
      int exp_cyc;
      logic [4:0] exp_err;
      exp_cyc = ERR_EN ? 32 : 30;
      exp_err = ERR_EN ? 5'd1 : 5'd0;
      fault_mode = 2;
      start_sweep(16'hC0A0);
      wait_done(cyc);
      checks += 5;
      if (cyc != exp_cyc)         begin errors++; $display("[TB] FAIL wrong_cycles: got %0d, expected %0d", cyc, exp_cyc); end
      if (pass !== 1'b0)          begin errors++; $display("[TB] FAIL wrong_pass: got %0b, expected 0", pass); end
      if (fail_idx !== 4'd14)     begin errors++; $display("[TB] FAIL wrong_fail_idx: got %0d, expected 14", fail_idx); end
      if (fail_kind !== 2'b10)    begin errors++; $display("[TB] FAIL wrong_fail_kind: got %0d, expected 2", fail_kind); end
      if (err_cnt !== exp_err)    begin errors++; $display("[TB] FAIL wrong_err_cnt: got %0d, expected %0d", err_cnt, exp_err); end
      fault_mode = 0;
   endtask

   // SETTLE_CYC=3 instance: each vector held 4 cycles, done on cycle 64.
   task automatic test_settle3;
      @(negedge clk);
      expected3 = 16'hC0A0;
      start3    = 1'b1;
      @(posedge clk);
      #1;
      start3 = 1'b0;
      for (int k = 1; k <= 64; k++) begin
         @(posedge clk);
         #1;
         if (k < 64) begin
            checks++;
            if (stim3 !== 4'(k / 4)) begin
               errors++;
               $display("[TB] FAIL s3_stim_k%0d: got %0d, expected %0d", k, stim3, k / 4);
            end
            checks++;
            if (done3 !== 1'b0) begin errors++; $display("[TB] FAIL s3_done_early_k%0d: got %0b, expected 0", k, done3); end
         end
      end
      checks += 2;
      if (done3 !== 1'b1) begin errors++; $display("[TB] FAIL s3_done: got %0b, expected 1", done3); end
      if (pass3 !== 1'b1) begin errors++; $display("[TB] FAIL s3_pass: got %0b, expected 1", pass3); end
   endtask

   // Reset mid-sweep at stim=9, then a clean sweep from vector 0.
   task automatic test_reset_mid;
      int cyc;
      int guard;
      fault_mode = 0;
      start_sweep(16'hC0A0);
      guard = 0;
      while (stim !== 4'd9 && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      checks++;
      if (stim !== 4'd9) begin errors++; $display("[TB] FAIL rst_reach9: got %0d, expected 9", stim); end
      #2;
      rst = 1'b1;
      #1;
      checks += 5;
      if (stim !== 4'd0)      begin errors++; $display("[TB] FAIL rst_mid_stim: got %0d, expected 0", stim); end
      if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL rst_mid_busy: got %0b, expected 0", busy); end
      if (done !== 1'b0)      begin errors++; $display("[TB] FAIL rst_mid_done: got %0b, expected 0", done); end
      if (pass !== 1'b0)      begin errors++; $display("[TB] FAIL rst_mid_pass: got %0b, expected 0", pass); end
      if (fail_kind !== 2'd0) begin errors++; $display("[TB] FAIL rst_mid_fail_kind: got %0d, expected 0", fail_kind); end
      @(negedge clk);
      rst = 1'b0;
      start_sweep(16'hC0A0);
      checks += 2;
      if (stim !== 4'd0) begin errors++; $display("[TB] FAIL rst_restart_stim: got %0d, expected 0", stim); end
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_restart_busy: got %0b, expected 1", busy); end
      wait_done(cyc);
      checks += 2;
      if (cyc != 32)     begin errors++; $display("[TB] FAIL rst_restart_cycles: got %0d, expected 32", cyc); end
      if (pass !== 1'b1) begin errors++; $display("[TB] FAIL rst_restart_pass: got %0b, expected 1", pass); end
   endtask

   // start re-pulsed while busy with a different table: no restart, and the
   // originally latched table still decides the result.
   task automatic test_back_to_back;
      int cyc;
      fault_mode = 0;
      start_sweep(16'hC0A0);
      repeat (6) @(posedge clk);
      @(negedge clk);
      expected = 16'h3F5F;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checks += 2;
      if (stim !== 4'd3) begin errors++; $display("[TB] FAIL b2b_stim: got %0d, expected 3", stim); end
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy: got %0b, expected 1", busy); end
      wait_done(cyc);
      checks += 3;
      if (cyc + 7 != 32)      begin errors++; $display("[TB] FAIL b2b_cycles: got %0d, expected 32", cyc + 7); end
      if (pass !== 1'b1)      begin errors++; $display("[TB] FAIL b2b_pass: got %0b, expected 1", pass); end
      if (fail_kind !== 2'd0) begin errors++; $display("[TB] FAIL b2b_fail_kind: got %0d, expected 0", fail_kind); end
      expected = 16'hC0A0;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      fault_mode = 0;
      rst        = 1'b1;
      start      = 1'b0;
      start3     = 1'b0;
      expected   = 16'h0000;
      expected3  = 16'h0000;
      test_reset;
      test_pass_sweep;
      test_disagree;
      test_wrong;
      test_settle3;
      test_reset_mid;
      test_back_to_back;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tt_sweep_ctrl.md
# tt_sweep_ctrl

Self-test sequencer for small combinational truth-table blocks. It drives every input vector of an IN_W-bit function into NUM_IMPL parallel implementations of that function (gate-level, dataflow, behavioural). For each vector it checks that all implementations agree and match a caller-supplied expected truth table, then reports pass/fail with the first failing vector. It replaces the open-loop exhaustive bench with a synthesizable, clocked checker that sits beside the implementations under test.

## Interface
Parameters:
- IN_W, default 4: stimulus width; sweep covers 2**IN_W vectors.
- NUM_IMPL, default 3: number of implementations compared; legal range ≥1.
- SETTLE_CYC, default 1: cycles each vector is held before sampling; legal range ≥1.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- start, input, 1: begin a sweep; honoured only in IDLE or DONE.
- expected, input, 2**IN_W: expected output per vector, bit i = f(i); latched on accepted start.
- impl_out, input, NUM_IMPL: output bit of each implementation.
- stim, output, IN_W: vector driven to all implementations.
- busy, output, 1: high in SETTLE/CHECK.
- done, output, 1: high in DONE, held until next accepted start or reset.
- pass, output, 1: valid while done; 1 = no failure seen.
- fail_idx, output, IN_W: first failing vector; 0 if pass.
- fail_kind, output, 2: bit0 = implementations disagree; bit1 = impl_out[0] ≠ expected[stim]; captured at first failure.
- err_cnt, output, IN_W+1: failing-vector count (see Configuration).

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE + start=1: latch expected, stim←0, settle counter←0, clear pass/fail_idx/fail_kind/err_cnt (pass←1), go SETTLE.
- SETTLE: counter increments each cycle; when counter = SETTLE_CYC-1, go CHECK. stim constant.
- CHECK: sample impl_out. disagree = not all bits equal; wrong = impl_out[0] ≠ expected_q[stim]. On failure (disagree|wrong): pass←0, err_cnt+1 (saturating at 2**IN_W). On the first failure of the sweep, also fail_idx←stim, fail_kind←{wrong,disagree}.
- After CHECK: if stim = all-ones, or (macro absent and failure), go DONE; else stim←stim+1, counter←0, go SETTLE. stim never wraps to 0 within a sweep.
- start while busy: ignored; expected not re-latched.
- start in same cycle DONE is entered: ignored (start only sampled in IDLE/DONE state register value).
- Changing expected mid-sweep has no effect.

## Timing
- Reset values: stim=0, busy=0, done=0, pass=0, fail_idx=0, fail_kind=0, err_cnt=0, state IDLE.
- rst asserted mid-sweep: immediate return to reset values; no partial result retained.
- start sampled at edge N → busy=1 and stim=0 from N+1.
- Per vector: SETTLE_CYC cycles SETTLE + 1 cycle CHECK. Full pass sweep: 2**IN_W·(SETTLE_CYC+1) cycles from N+1 to the edge raising done (defaults: 32).
- Early stop (macro absent): done rises the cycle after the failing CHECK.
- All outputs registered; no combinational path input→output.

## Configuration
- TT_SWEEP_ERR_CNT_EN defined: sweep always runs all vectors; err_cnt counts failing vectors; fail_idx/fail_kind still report the first failure.
- Undefined: sweep stops at first failure; err_cnt tied to 0 (pass=1 ⇒ 0 failures; pass=0 ⇒ exactly one reported).

## Structure
- Package tt_sweep_pkg: state enum (IDLE, SETTLE, CHECK, DONE), fail_kind bit constants FK_DISAGREE=0, FK_WRONG=1.
- Sub-module tt_sweep_cmp: combinational; inputs impl_out, expected bit; outputs disagree, wrong. Controller instantiates one.

## Test plan
- Three correct implementations of f=1 for {5,7,14,15}, expected=16'hC0A0, start → done after 32 cycles, pass=1, fail_idx=0, fail_kind=0, err_cnt=0.
- impl 1 forced to 1 at vector 3 only, macro off → done the cycle after the CHECK of vector 3, pass=0, fail_idx=3, fail_kind=2'b01.
- All implementations return 0 at vector 14, macro on → full 32-cycle sweep, pass=0, fail_idx=14, fail_kind=2'b10, err_cnt=1.
- SETTLE_CYC=3, correct implementations → stim holds each value 4 cycles, done at cycle 64.
- rst pulsed while stim=9, then start → all outputs at reset values after reset, then a clean sweep from stim=0 with pass=1.
- start re-pulsed while busy, and expected changed mid-sweep → no restart; result uses the originally latched table.
